// File: rtl/perip_responder.sv
// perip_responder: responder end of the CPU data-side peripheral bus.
// Decodes the byte address into data RAM, LED/switch registers, a prescaled
// tick counter and (optionally) a UART TX byte queue. Read data is
// combinational; writes commit on the rising cpu_clk edge.
// Optional feature macro: PERIP_TXQ_EN enables the TX queue and the
// TX_DATA/TX_STAT registers; without it tx_valid/tx_data stay 0 and those
// addresses read 0 and ignore writes.
module perip_responder #(
    parameter int DRAM_AW   = 14,
    parameter int CNT_DIV   = 50000,
    parameter int TXQ_DEPTH = 16
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] perip_addr,
    input  logic [31:0] perip_wdata,
    input  logic        perip_wen,
    input  logic [1:0]  perip_wen_mask,
    output logic [31:0] perip_rdata,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [31:0] DRAM_BASE     = 32'h8000_0000;
    localparam logic [31:0] LED_ADDR      = 32'h8020_0000;
    localparam logic [31:0] SW_ADDR       = 32'h8020_0004;
    localparam logic [31:0] CNT_CTRL_ADDR = 32'h8020_0010;
    localparam logic [31:0] CNT_VAL_ADDR  = 32'h8020_0014;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    // Prescaler needs at least one bit even when CNT_DIV is 1.
    localparam int PS_W = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CNT_DIV - 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

    // Byte-lane enables for a write; odd-aligned halves and the reserved
    // mask produce no lanes, which turns the write into a no-op.
    function automatic logic [3:0] lane_enables(input logic [1:0] mask,
                                                input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (mask)
            MASK_BYTE: be = 4'b0001 << lo;
            MASK_HALF: begin
                if (lo[0]) begin
                    be = 4'b0000;
                end else if (lo[1]) begin
                    be = 4'b1100;
                end else begin
                    be = 4'b0011;
                end
            end
            MASK_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    logic [31:0]        dram_r [2**DRAM_AW];
    logic [15:0]        led_r;
    logic [15:0]        sw_meta_r;
    logic [15:0]        sw_sync_r;
    logic               cnt_run_r;
    logic [PS_W-1:0]    cnt_ps_r;
    logic [31:0]        cnt_val_r;

    logic [31:0]        word_addr_s;
    logic               dram_sel_s;
    logic [DRAM_AW-1:0] dram_idx_s;
    logic [3:0]         be_s;
    logic               wr_s;
    logic               dram_we_s;
    logic               led_we_s;
    logic               ctrl_we_s;
    logic [31:0]        rdata_s;

    // Address decode and write qualification shared by all targets.
    always_comb begin
        word_addr_s = {perip_addr[31:2], 2'b00};
        dram_sel_s  = (perip_addr[31:DRAM_AW+2] == DRAM_BASE[31:DRAM_AW+2]);
        dram_idx_s  = perip_addr[DRAM_AW+1:2];
        be_s        = lane_enables(perip_wen_mask, perip_addr[1:0]);
        wr_s        = perip_wen && (be_s != 4'b0000);
        dram_we_s   = wr_s && dram_sel_s;
        led_we_s    = wr_s && !dram_sel_s && (word_addr_s == LED_ADDR);
        ctrl_we_s   = wr_s && !dram_sel_s && (word_addr_s == CNT_CTRL_ADDR) && be_s[0];
    end

    // Data RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge cpu_clk) begin
        if (dram_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    dram_r[dram_idx_s][8*b +: 8] <= perip_wdata[8*b +: 8];
                end
            end
        end
    end

    // LED register, lanes 0 and 1 only.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            led_r <= 16'h0000;
        end else if (led_we_s) begin
            if (be_s[0]) led_r[7:0]  <= perip_wdata[7:0];
            if (be_s[1]) led_r[15:8] <= perip_wdata[15:8];
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            sw_meta_r <= 16'h0000;
            sw_sync_r <= 16'h0000;
        end else begin
            sw_meta_r <= sw;
            sw_sync_r <= sw_meta_r;
        end
    end

    // Prescaled tick counter; clear wins over counting, run is applied
    // from the same write so clear+run restarts from zero.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            cnt_run_r <= 1'b0;
            cnt_ps_r  <= '0;
            cnt_val_r <= 32'h0000_0000;
        end else begin
            if (ctrl_we_s && perip_wdata[1]) begin
                cnt_ps_r  <= '0;
                cnt_val_r <= 32'h0000_0000;
            end else if (cnt_run_r) begin
                if (cnt_ps_r == PS_LAST) begin
                    cnt_ps_r  <= '0;
                    cnt_val_r <= cnt_val_r + 32'd1;
                end else begin
                    cnt_ps_r  <= cnt_ps_r + PS_ONE;
                end
            end
            if (ctrl_we_s) begin
                cnt_run_r <= perip_wdata[0];
            end
        end
    end

`ifdef PERIP_TXQ_EN
    localparam logic [31:0] TX_DATA_ADDR = 32'h8020_0020;
    localparam logic [31:0] TX_STAT_ADDR = 32'h8020_0024;
    localparam int          QW           = (TXQ_DEPTH > 2) ? $clog2(TXQ_DEPTH) : 1;
    localparam logic [QW:0] TXQ_FULL     = (QW+1)'(TXQ_DEPTH);
    localparam logic [QW:0] TXQ_ONE      = (QW+1)'(1);
    localparam logic [QW-1:0] PTR_ONE    = QW'(1);

    logic [7:0]    txq_mem_r [TXQ_DEPTH];
    logic [QW-1:0] txq_wr_ptr_r;
    logic [QW-1:0] txq_rd_ptr_r;
    logic [QW:0]   txq_count_r;
    logic [QW:0]   txq_count_next_s;
    logic          txq_ovf_r;
    logic          tx_valid_r;
    logic          txq_full_s;
    logic          txq_empty_s;
    logic          push_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          ovf_set_s;
    logic          stat_we_s;
    logic [7:0]    txq_count_8_s;

    // Queue handshake: a full queue still accepts a push when it pops too.
    always_comb begin
        txq_full_s    = (txq_count_r == TXQ_FULL);
        txq_empty_s   = (txq_count_r == '0);
        push_s        = wr_s && !dram_sel_s && (word_addr_s == TX_DATA_ADDR) &&
                        ((perip_wen_mask == MASK_WORD) || (perip_wen_mask == MASK_BYTE));
        pop_s         = tx_valid_r && tx_ready;
        push_ok_s     = push_s && (!txq_full_s || pop_s);
        ovf_set_s     = push_s && txq_full_s && !pop_s;
        stat_we_s     = wr_s && !dram_sel_s && (word_addr_s == TX_STAT_ADDR);
        txq_count_8_s = 8'(txq_count_r);
        if (push_ok_s && !pop_s) begin
            txq_count_next_s = txq_count_r + TXQ_ONE;
        end else if (pop_s && !push_ok_s) begin
            txq_count_next_s = txq_count_r - TXQ_ONE;
        end else begin
            txq_count_next_s = txq_count_r;
        end
    end

    // Queue storage; unread slots are never exposed so no reset needed.
    always_ff @(posedge cpu_clk) begin
        if (push_ok_s) begin
            txq_mem_r[txq_wr_ptr_r] <= perip_wdata[7:0];
        end
    end

    // Queue pointers, occupancy, valid flag and sticky overflow.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            txq_wr_ptr_r <= '0;
            txq_rd_ptr_r <= '0;
            txq_count_r  <= '0;
            tx_valid_r   <= 1'b0;
            txq_ovf_r    <= 1'b0;
        end else begin
            if (push_ok_s) txq_wr_ptr_r <= txq_wr_ptr_r + PTR_ONE;
            if (pop_s)     txq_rd_ptr_r <= txq_rd_ptr_r + PTR_ONE;
            txq_count_r <= txq_count_next_s;
            tx_valid_r  <= (txq_count_next_s != '0);
            if (ovf_set_s) begin
                txq_ovf_r <= 1'b1;
            end else if (stat_we_s) begin
                txq_ovf_r <= 1'b0;
            end
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_valid_r ? txq_mem_r[txq_rd_ptr_r] : 8'h00;
`else
    logic unused_tx_ready_s;
    assign unused_tx_ready_s = tx_ready;
    assign tx_valid = 1'b0;
    assign tx_data  = 8'h00;
`endif

    // Zero-latency read mux; anything unmapped reads as zero.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (dram_sel_s) begin
            rdata_s = dram_r[dram_idx_s];
        end else begin
            case (word_addr_s)
                LED_ADDR:      rdata_s = {16'h0000, led_r};
                SW_ADDR:       rdata_s = {16'h0000, sw_sync_r};
                CNT_CTRL_ADDR: rdata_s = {31'h0000_0000, cnt_run_r};
                CNT_VAL_ADDR:  rdata_s = cnt_val_r;
`ifdef PERIP_TXQ_EN
                TX_STAT_ADDR:  rdata_s = {16'h0000, txq_count_8_s, 5'b00000,
                                          txq_ovf_r, txq_empty_s, txq_full_s};
`endif
                default:       rdata_s = 32'h0000_0000;
            endcase
        end
    end

    assign perip_rdata = rdata_s;
    assign led         = led_r;

endmodule

// File: tb/tb_perip_responder.sv
// Scoreboard bench for perip_responder: reads and TX handshakes push
// expected values into queues; a negedge monitor pops and compares.
module tb_perip_responder;

    localparam int DRAM_AW   = 6;
    localparam int CNT_DIV   = 4;
    localparam int TXQ_DEPTH = 16;

    localparam logic [31:0] A_LED  = 32'h8020_0000;
    localparam logic [31:0] A_SW   = 32'h8020_0004;
    localparam logic [31:0] A_CTRL = 32'h8020_0010;
    localparam logic [31:0] A_VAL  = 32'h8020_0014;
    localparam logic [31:0] A_TXD  = 32'h8020_0020;
    localparam logic [31:0] A_TXS  = 32'h8020_0024;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [31:0] perip_addr;
    logic [31:0] perip_wdata;
    logic        perip_wen;
    logic [1:0]  perip_wen_mask;
    logic [31:0] perip_rdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rd_en;

    int checks = 0;
    int passes = 0;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic [7:0]  tx_exp_q[$];

    perip_responder #(
        .DRAM_AW(DRAM_AW), .CNT_DIV(CNT_DIV), .TXQ_DEPTH(TXQ_DEPTH)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .perip_addr(perip_addr), .perip_wdata(perip_wdata),
        .perip_wen(perip_wen), .perip_wen_mask(perip_wen_mask),
        .perip_rdata(perip_rdata), .sw(sw), .led(led),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: compares read data and TX handshakes against the scoreboard.
    always @(negedge cpu_clk) begin
        if (rd_en) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                $display("FAIL rd_unexpected: got 0x%08h, expected no read", perip_rdata);
            end else begin
                check(rd_name_q.pop_front(), perip_rdata, rd_exp_q.pop_front());
            end
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_exp_q.size() == 0) begin
                checks++;
                $display("FAIL tx_unexpected: got 0x%02h, expected no byte", tx_data);
            end else begin
                check("tx_byte", {24'h000000, tx_data}, {24'h000000, tx_exp_q.pop_front()});
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        perip_addr = a; perip_wdata = d; perip_wen_mask = m; perip_wen = 1'b1;
        @(posedge cpu_clk); #1;
        perip_wen = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
        perip_addr = a; rd_en = 1'b1;
        rd_exp_q.push_back(e); rd_name_q.push_back(name);
        @(posedge cpu_clk); #1;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge cpu_clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        cpu_rst = 1'b0; perip_addr = 32'h0; perip_wdata = 32'h0; perip_wen = 1'b0;
        perip_wen_mask = 2'b10; sw = 16'h0000; tx_ready = 1'b0; rd_en = 1'b0;
        #2 cpu_rst = 1'b1;
        idle(2);
        // reset state
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        rd("rst_led_rd", A_LED, 32'h0);
        rd("rst_cnt_val", A_VAL, 32'h0);
`ifdef PERIP_TXQ_EN
        rd("rst_tx_stat", A_TXS, 32'h0000_0002);
`else
        rd("rst_tx_stat", A_TXS, 32'h0);
`endif
        cpu_rst = 1'b0;
        idle(1);

        // DRAM lanes
        wr(32'h8000_0008, 32'h1122_3344, 2'b10);
        wr(32'h8000_000B, 32'hAA00_0000, 2'b00);
        rd("dram_byte", 32'h8000_0008, 32'hAA22_3344);
        wr(32'h8000_0008, 32'h5555_BEEF, 2'b01);
        wr(32'h8000_0009, 32'hFFFF_FFFF, 2'b01);
        rd("dram_half_lo", 32'h8000_0008, 32'hAA22_BEEF);
        wr(32'h8000_000A, 32'h1234_0000, 2'b01);
        wr(32'h8000_0008, 32'h0000_0000, 2'b11);
        rd("dram_half_hi", 32'h8000_0008, 32'h1234_BEEF);
        wr(32'h8000_0000, 32'hDEAD_BEEF, 2'b10);
        rd("dram_word0", 32'h8000_0000, 32'hDEAD_BEEF);

        // LED, unmapped, reserved mask
        wr(A_LED, 32'hFFFF_A5A5, 2'b10);
        check("led_out", {16'h0, led}, 32'h0000_A5A5);
        rd("led_rd", A_LED, 32'h0000_A5A5);
        wr(32'h8020_0008, 32'hFFFF_FFFF, 2'b10);
        wr(A_LED, 32'h0000_0000, 2'b11);
        rd("led_keep", A_LED, 32'h0000_A5A5);
        rd("unmapped_reg", 32'h8020_0008, 32'h0);
        rd("unmapped_hi", 32'h9000_0000, 32'h0);
        rd("unmapped_dram_end", 32'h8000_0100, 32'h0);

        // switch synchronizer: visible after two edges
        sw = 16'h00F0;
        rd("sw_edge0", A_SW, 32'h0);
        rd("sw_edge1", A_SW, 32'h0);
        rd("sw_edge2", A_SW, 32'h0000_00F0);

        // counter
        wr(A_CTRL, 32'h3, 2'b10);
        idle(20);
        rd("cnt_20cyc", A_VAL, 32'd5);
        rd("cnt_ctrl_rd", A_CTRL, 32'h1);
        wr(A_CTRL, 32'h0, 2'b10);
        idle(8);
        rd("cnt_hold", A_VAL, 32'd5);
        wr(A_CTRL, 32'h2, 2'b10);
        rd("cnt_clear", A_VAL, 32'h0);
        force dut.cnt_val_r = 32'hFFFF_FFFF;
        #1 release dut.cnt_val_r;
        rd("cnt_preload", A_VAL, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'h1, 2'b10);
        idle(3);
        rd("cnt_pre_wrap", A_VAL, 32'hFFFF_FFFF);
        rd("cnt_wrap", A_VAL, 32'h0);

`ifdef PERIP_TXQ_EN
        // overflow on 17th push, drain in order
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b = 8'h10 + 8'(i);
            if (i < 16) tx_exp_q.push_back(b);
            wr(A_TXD, {24'h0, b}, 2'b10);
        end
        check("txq_valid_full", {31'h0, tx_valid}, 32'h1);
        check("txq_head", {24'h0, tx_data}, 32'h10);
        rd("txq_stat_ovf", A_TXS, 32'h0000_1005);
        tx_ready = 1'b1;
        idle(16);
        tx_ready = 1'b0;
        check("txq_drained", tx_exp_q.size(), 32'd0);
        check("txq_valid_empty", {31'h0, tx_valid}, 32'h0);
        rd("txq_stat_sticky", A_TXS, 32'h0000_0006);
        wr(A_TXS, 32'h0, 2'b10);
        rd("txq_stat_clr", A_TXS, 32'h0000_0002);

        // full queue push with simultaneous pop
        for (int i = 0; i < 16; i++) begin
            b = 8'h40 + 8'(i);
            tx_exp_q.push_back(b);
            wr(A_TXD, {24'h0, b}, 2'b10);
        end
        tx_exp_q.push_back(8'h50);
        tx_ready = 1'b1;
        wr(A_TXD, 32'h0000_0050, 2'b10);
        tx_ready = 1'b0;
        check("txq_head_after_pp", {24'h0, tx_data}, 32'h41);
        rd("txq_stat_pp", A_TXS, 32'h0000_1001);
        tx_ready = 1'b1;
        idle(16);
        tx_ready = 1'b0;
        check("txq_pp_drained", tx_exp_q.size(), 32'd0);

        // byte push accepted, half push ignored
        tx_exp_q.push_back(8'hAB);
        wr(A_TXD, 32'h0000_00AB, 2'b00);
        wr(A_TXD, 32'h0000_00CD, 2'b01);
        check("txq_empty_push_valid", {31'h0, tx_valid}, 32'h1);
        rd("txq_stat_one", A_TXS, 32'h0000_0100);
        tx_ready = 1'b1;
        idle(2);
        tx_ready = 1'b0;
        check("txq_byte_drained", tx_exp_q.size(), 32'd0);

        // five queued for the reset test
        for (int i = 0; i < 5; i++) begin
            b = 8'h60 + 8'(i);
            wr(A_TXD, {24'h0, b}, 2'b10);
        end
        check("txq_pre_rst_valid", {31'h0, tx_valid}, 32'h1);
`else
        wr(A_TXD, 32'h0000_0055, 2'b10);
        check("notxq_valid", {31'h0, tx_valid}, 32'h0);
        check("notxq_data", {24'h0, tx_data}, 32'h0);
        rd("notxq_stat", A_TXS, 32'h0);
        rd("notxq_txd", A_TXD, 32'h0);
        idle(8);
`endif

        // asynchronous reset mid-stream
        wr(A_LED, 32'h0000_1234, 2'b10);
        idle(3);
        perip_addr = A_VAL;
        cpu_rst = 1'b1;
        #1;
        tx_exp_q.delete();
        check("rst_mid_led", {16'h0, led}, 32'h0);
        check("rst_mid_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_mid_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_mid_cnt_val", perip_rdata, 32'h0);
        idle(1);
        cpu_rst = 1'b0;
        rd("rst_dram_kept", 32'h8000_0008, 32'h1234_BEEF);
        rd("rst_ctrl", A_CTRL, 32'h0);
        idle(2);
        check("rd_queue_empty", rd_exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
